// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file access controller.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;

    typedef logic [3:0] reg_addr_t;

    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LOAD = 1'b1
    } wb_port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Grant is combinational from req and state; the pointer moves only on a grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_valid,
    output wb_port_e   gnt_port
);

    wb_port_e last_q;
    wb_port_e last_d;

    always_comb begin
        gnt_valid = |req;
        gnt_port  = WB_ALU;
        if (req[0] && req[1]) begin
            gnt_port = (last_q == WB_ALU) ? WB_LOAD : WB_ALU;
        end else if (req[1]) begin
            gnt_port = WB_LOAD;
        end

        gnt = 2'b00;
        if (gnt_valid) begin
            gnt = (gnt_port == WB_LOAD) ? 2'b10 : 2'b01;
        end

        last_d = gnt_valid ? gnt_port : last_q;
    end

    // Reset to the load port so the ALU wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= WB_LOAD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file access controller: write-port arbitration, destination scoreboard, hazard stall.
// Define REGFILE_CTRL_BYPASS_EN to forward same-cycle write data instead of stalling.
module regfile_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  reg_addr_t         rd_addr_a,
    input  reg_addr_t         rd_addr_b,
    input  logic              rsv_en,
    input  reg_addr_t         rsv_addr,
    output logic              rd_resp_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,

    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  reg_addr_t         wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,

    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  reg_addr_t         wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,

    output logic              rf_enable_n,
    output logic              rf_write_en,
    output reg_addr_t         rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output reg_addr_t         rf_read_addr_a,
    output reg_addr_t         rf_read_addr_b,
    input  logic [DATA_W-1:0] rf_read_data_a,
    input  logic [DATA_W-1:0] rf_read_data_b
);

    logic [1:0]          gnt;
    logic                wr_valid;
    wb_port_e            wr_port;
    reg_addr_t           wr_addr;
    logic [DATA_W-1:0]   wr_data;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] pend_src;

    logic                src_hazard;
    logic                waw_hazard;
    logic                rd_accept;
    logic                resp_valid_q;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({wb1_valid, wb0_valid}),
        .gnt       (gnt),
        .gnt_valid (wr_valid),
        .gnt_port  (wr_port)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];

    always_comb begin
        wr_addr = wb0_addr;
        wr_data = wb0_data;
        if (wr_port == WB_LOAD) begin
            wr_addr = wb1_addr;
            wr_data = wb1_data;
        end
    end

    assign rf_write_en    = wr_valid;
    assign rf_write_addr  = wr_addr;
    assign rf_write_data  = wr_data;
    assign rf_read_addr_a = rd_addr_a;
    assign rf_read_addr_b = rd_addr_b;

    always_comb begin
        clr_mask = '0;
        if (wr_valid) begin
            clr_mask[wr_addr] = 1'b1;
        end
    end

`ifdef REGFILE_CTRL_BYPASS_EN
    // A source being written this cycle is forwarded next cycle, so it no longer blocks.
    assign pend_src   = pending_q & ~clr_mask;
    assign src_hazard = pend_src[rd_addr_a] | pend_src[rd_addr_b];
`else
    assign pend_src   = pending_q;
    assign src_hazard = pend_src[rd_addr_a] | pend_src[rd_addr_b] |
                        (wr_valid && (wr_addr != '0) &&
                         ((wr_addr == rd_addr_a) || (wr_addr == rd_addr_b)));
`endif

    assign waw_hazard   = rsv_en & pending_q[rsv_addr];
    assign rd_req_ready = ~(src_hazard | waw_hazard | flush);
    assign rd_accept    = rd_req_valid & rd_req_ready;
    assign rf_enable_n  = ~(rd_accept | wr_valid);

    always_comb begin
        set_mask = '0;
        if (rd_accept && rsv_en && (rsv_addr != '0)) begin
            set_mask[rsv_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reserve of the written register wins.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | set_mask;
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            resp_valid_q <= rd_accept;
        end
    end

    assign rd_resp_valid = resp_valid_q;

`ifdef REGFILE_CTRL_BYPASS_EN
    logic              byp_a_q;
    logic              byp_b_q;
    logic [DATA_W-1:0] byp_data_q;
    logic              wr_live;

    // The register file returns the pre-write value, so the write data is captured here.
    assign wr_live = wr_valid && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_a_q    <= 1'b0;
            byp_b_q    <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_a_q    <= rd_accept && wr_live && (wr_addr == rd_addr_a);
            byp_b_q    <= rd_accept && wr_live && (wr_addr == rd_addr_b);
            byp_data_q <= wr_data;
        end
    end

    assign rd_data_a = byp_a_q ? byp_data_q : rf_read_data_a;
    assign rd_data_b = byp_b_q ? byp_data_q : rf_read_data_b;
`else
    assign rd_data_a = rf_read_data_a;
    assign rd_data_b = rf_read_data_b;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl with a behavioural 16x32 register file.
module tb_regfile_ctrl;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              rd_req_valid;
    logic              rd_req_ready;
    reg_addr_t         rd_addr_a, rd_addr_b, rsv_addr;
    logic              rsv_en;
    logic              rd_resp_valid;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              wb0_valid, wb0_ready, wb1_valid, wb1_ready;
    reg_addr_t         wb0_addr, wb1_addr;
    logic [DATA_W-1:0] wb0_data, wb1_data;
    logic              rf_enable_n, rf_write_en;
    reg_addr_t         rf_write_addr, rf_read_addr_a, rf_read_addr_b;
    logic [DATA_W-1:0] rf_write_data, rf_read_data_a, rf_read_data_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .rd_req_valid   (rd_req_valid),
        .rd_req_ready   (rd_req_ready),
        .rd_addr_a      (rd_addr_a),
        .rd_addr_b      (rd_addr_b),
        .rsv_en         (rsv_en),
        .rsv_addr       (rsv_addr),
        .rd_resp_valid  (rd_resp_valid),
        .rd_data_a      (rd_data_a),
        .rd_data_b      (rd_data_b),
        .wb0_valid      (wb0_valid),
        .wb0_ready      (wb0_ready),
        .wb0_addr       (wb0_addr),
        .wb0_data       (wb0_data),
        .wb1_valid      (wb1_valid),
        .wb1_ready      (wb1_ready),
        .wb1_addr       (wb1_addr),
        .wb1_data       (wb1_data),
        .rf_enable_n    (rf_enable_n),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_read_addr_a (rf_read_addr_a),
        .rf_read_addr_b (rf_read_addr_b),
        .rf_read_data_a (rf_read_data_a),
        .rf_read_data_b (rf_read_data_b)
    );

    // Register file: r0 reads zero, registered reads see the pre-write value.
    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
            rf_read_data_a <= '0;
            rf_read_data_b <= '0;
        end else if (!rf_enable_n) begin
            rf_read_data_a <= (rf_read_addr_a == '0) ? '0 : rf_mem[rf_read_addr_a];
            rf_read_data_b <= (rf_read_addr_b == '0) ? '0 : rf_mem[rf_read_addr_b];
            if (rf_write_en && rf_write_addr != '0) rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    task automatic idle_inputs();
        flush = 0; rd_req_valid = 0; rd_addr_a = 0; rd_addr_b = 0; rsv_en = 0; rsv_addr = 0;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0; wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
    endtask

    task automatic drive_read(input reg_addr_t a, input reg_addr_t b, input logic en,
                              input reg_addr_t r);
        rd_req_valid = 1; rd_addr_a = a; rd_addr_b = b; rsv_en = en; rsv_addr = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (rd_resp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_resp_valid: got %b want 0", rd_resp_valid);
        end
        tests_run++;
        if (rf_enable_n !== 1'b1) begin
            tests_failed++; $display("FAIL reset_enable_n: got %b want 1", rf_enable_n);
        end
        tests_run++;
        if (rf_write_en !== 1'b0) begin
            tests_failed++; $display("FAIL reset_write_en: got %b want 0", rf_write_en);
        end
        @(negedge clk);
        reset = 0;
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: got %b want 1", rd_req_ready);
        end
    endtask

    task automatic test_read_basic();
        @(negedge clk);
        drive_read(4'd0, 4'd5, 1'b0, 4'd0);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1 || rf_enable_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_accept: ready=%b en_n=%b want 1/0", rd_req_ready, rf_enable_n);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (rd_resp_valid !== 1'b1 || rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL basic_resp: valid=%b a=%h b=%h want 1/0/0",
                     rd_resp_valid, rd_data_a, rd_data_b);
        end
        tests_run++;
        if (rf_enable_n !== 1'b1) begin
            tests_failed++; $display("FAIL basic_idle_en_n: got %b want 1", rf_enable_n);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rd_resp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL basic_one_shot: got %b want 0", rd_resp_valid);
        end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        @(negedge clk);
        drive_read(4'd1, 4'd2, 1'b1, 4'd3);
        @(posedge clk);
        @(negedge clk);
        drive_read(4'd3, 4'd0, 1'b0, 4'd0);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL raw_stall: ready=%b want 0", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb0_valid = 1; wb0_addr = 4'd3; wb0_data = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (wb0_ready !== 1'b1) begin
            tests_failed++; $display("FAIL raw_wb0_grant: got %b want 1", wb0_ready);
        end
`ifdef REGFILE_CTRL_BYPASS_EN
        tests_run++;
        if (rd_req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL raw_bypass_ready: got %b want 1", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
`else
        tests_run++;
        if (rd_req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL raw_write_cycle_stall: got %b want 0", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb0_valid = 0;
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL raw_after_write_ready: got %b want 1", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
`endif
        #1;
        tests_run++;
        if (rd_resp_valid !== 1'b1 || rd_data_a !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL raw_data: valid=%b a=%h want 1/deadbeef", rd_resp_valid, rd_data_a);
        end
    endtask

    task automatic test_arbitration();
        logic exp0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb0_valid = 1; wb0_addr = 4'd10; wb0_data = 32'hA0 + i;
            wb1_valid = 1; wb1_addr = 4'd11; wb1_data = 32'hB0 + i;
            #1;
            exp0 = (i % 2 == 0);
            tests_run++;
            if (wb0_ready !== exp0 || wb1_ready !== !exp0) begin
                tests_failed++;
                $display("FAIL arb_cycle%0d: wb0=%b wb1=%b want %b/%b",
                         i, wb0_ready, wb1_ready, exp0, !exp0);
            end
            tests_run++;
            if (rf_write_addr !== (exp0 ? 4'd10 : 4'd11)) begin
                tests_failed++;
                $display("FAIL arb_addr%0d: got %0d want %0d", i, rf_write_addr,
                         exp0 ? 10 : 11);
            end
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        wb1_valid = 1; wb1_addr = 4'd12; wb1_data = 32'hC0;
        #1;
        tests_run++;
        if (wb1_ready !== 1'b1 || wb0_ready !== 1'b0) begin
            tests_failed++; $display("FAIL arb_single: wb1=%b wb0=%b want 1/0", wb1_ready, wb0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        drive_read(4'd10, 4'd11, 1'b0, 4'd0);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (rd_data_a !== 32'hA2 || rd_data_b !== 32'hB3) begin
            tests_failed++;
            $display("FAIL arb_final_data: a=%h b=%h want a2/b3", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_waw();
        do_reset();
        @(negedge clk);
        drive_read(4'd1, 4'd2, 1'b1, 4'd7);
        @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL waw_stall: ready=%b want 0", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb1_valid = 1; wb1_addr = 4'd7; wb1_data = 32'h77;
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b0 || wb1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL waw_write_cycle: ready=%b wb1=%b want 0/1", rd_req_ready, wb1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb1_valid = 0;
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1 || rf_enable_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL waw_accept: ready=%b en_n=%b want 1/0", rd_req_ready, rf_enable_n);
        end
        @(posedge clk);
        @(negedge clk);
        drive_read(4'd7, 4'd0, 1'b0, 4'd0);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL waw_repending: ready=%b want 0", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_r0_write();
        do_reset();
        @(negedge clk);
        wb0_valid = 1; wb0_addr = 4'd0; wb0_data = 32'h1234;
        drive_read(4'd0, 4'd0, 1'b0, 4'd0);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1 || rf_write_en !== 1'b1 || rf_write_addr !== 4'd0) begin
            tests_failed++;
            $display("FAIL r0_issue: ready=%b we=%b wa=%0d want 1/1/0",
                     rd_req_ready, rf_write_en, rf_write_addr);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (rd_resp_valid !== 1'b1 || rd_data_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL r0_data: valid=%b a=%h want 1/0", rd_resp_valid, rd_data_a);
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        drive_read(4'd1, 4'd4, 1'b1, 4'd2);
        @(posedge clk);
        @(negedge clk);
        drive_read(4'd1, 4'd4, 1'b1, 4'd9);
        @(posedge clk);
        @(negedge clk);
        drive_read(4'd2, 4'd9, 1'b0, 4'd0);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL flush_pre_stall: ready=%b want 0", rd_req_ready);
        end
        flush = 1;
        wb0_valid = 1; wb0_addr = 4'd12; wb0_data = 32'h55;
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b0 || wb0_ready !== 1'b1 || rf_write_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_cycle: ready=%b wb0=%b we=%b want 0/1/1",
                     rd_req_ready, wb0_ready, rf_write_en);
        end
        @(posedge clk);
        @(negedge clk);
        flush = 0; wb0_valid = 0;
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL flush_cleared: ready=%b want 1", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle_inputs();
        drive_read(4'd1, 4'd2, 1'b1, 4'd5);
        reset = 1;
        @(posedge clk); #1;
        tests_run++;
        if (rd_resp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_resp: got %b want 0", rd_resp_valid);
        end
        @(negedge clk);
        reset = 0;
        drive_read(4'd5, 4'd0, 1'b0, 4'd0);
        #1;
        tests_run++;
        if (rd_req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_rsv_lost: ready=%b want 1", rd_req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_read_basic();
        test_raw_hazard();
        test_arbitration();
        test_waw();
        test_r0_write();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
